limber_fifo_wr_arb: RTL and testbench

LIMBER_FIFO_WR_ARB -- requirements
Module: limber_fifo_wr_arb

---
 rtl/limber_fifo_wr_arb.sv | 111 +++++++++++
 tb/tb_limber_fifo_wr_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limber_fifo_wr_arb.sv
// rtl/limber_fifo_wr_arb.sv - round-robin burst arbiter for NREQ writers sharing one sync FIFO
// A grant lasts until MAXB beats are written or the owner drops req; fifo_full stalls without timeout.
module limber_fifo_wr_arb #(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  parameter  int MAXB = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(MAXB + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      ack,
  input  logic                 fifo_full,
  output logic                 fifo_wen,
  output logic [DW-1:0]        fifo_din,
  output logic [PW-1:0]        owner,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic [PW-1:0] owner_inc;
  logic          beat;

  // Descending scan so the index closest to ptr (smallest offset) wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  assign owner_inc = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        beat = req[owner_q] & ~fifo_full;
        if (!req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(MAXB - 1)) begin
            state_d = IDLE;
            ptr_d   = owner_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs derive from registered state, so reset clears them without a clock edge.
  assign fifo_wen = beat;
  assign ack      = beat ? (NREQ'(1) << owner_q) : '0;
  assign fifo_din = din[owner_q*DW +: DW];
  assign owner    = owner_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_limber_fifo_wr_arb.sv
// tb/tb_limber_fifo_wr_arb.sv - directed self-checking bench for limber_fifo_wr_arb
module tb_limber_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] din = 32'h44332211;
  logic            fifo_full = 1'b0;
  logic [NREQ-1:0] ack;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      owner;
  logic            busy;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] obs;
  logic [7:0] exp_v;
  logic [7:0] dv [NREQ];

  assign obs = {busy, fifo_wen, ack, owner};

  limber_fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAXB(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    ncmp++;
    if (obs !== 8'b0000_0000) begin
      $display("FAIL reset_state: {busy,wen,ack,owner}=%b required %b", obs, 8'b0);
      nerr++;
    end
    ncmp++;
    if (fifo_din !== 8'h11) begin
      $display("FAIL reset_din: fifo_din=%h required %h", fifo_din, 8'h11);
      nerr++;
    end
    req = 4'b0100;
    step();
    ncmp++;
    if (obs !== 8'b0000_0000) begin
      $display("FAIL reset_hold: {busy,wen,ack,owner}=%b required %b", obs, 8'b0);
      nerr++;
    end
    req = '0;
    rst = 1'b1;
  endtask

  task automatic test_single;
    req = 4'b0001;
    #1;
    ncmp++;
    if (obs !== 8'b0000_0000) begin
      $display("FAIL single_c0: {busy,wen,ack,owner}=%b required %b", obs, 8'b0);
      nerr++;
    end
    for (int c = 1; c <= 3; c++) begin
      step(); #1;
      ncmp++;
      if (obs !== 8'b1100_0100 || fifo_din !== 8'h11) begin
        $display("FAIL single_beat c%0d: obs=%b din=%h required %b din=%h", c, obs, fifo_din, 8'b1100_0100, 8'h11);
        nerr++;
      end
    end
    step();
    req = '0;
    #1;
    ncmp++;
    if (obs !== 8'b1000_0000) begin
      $display("FAIL single_drop c4: obs=%b required %b", obs, 8'b1000_0000);
      nerr++;
    end
    step(); #1;
    ncmp++;
    if (obs !== 8'b0000_0000) begin
      $display("FAIL single_idle c5: obs=%b required %b", obs, 8'b0000_0000);
      nerr++;
    end
    req = 4'b1111;
    step(); #1;
    ncmp++;
    if (obs !== 8'b1100_1001) begin
      $display("FAIL single_ptr: obs=%b required %b", obs, 8'b1100_1001);
      nerr++;
    end
    do_reset();
  endtask

  task automatic test_fairness;
    int nwen;
    int e;
    int pe;
    nwen = 0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e  = g % NREQ;
      pe = (g == 0) ? 0 : (g - 1) % NREQ;
      #1;
      exp_v = {1'b0, 1'b0, 4'b0000, pe[1:0]};
      ncmp++;
      if (obs !== exp_v) begin
        $display("FAIL fair_idle g%0d: obs=%b required %b", g, obs, exp_v);
        nerr++;
      end
      for (int b = 0; b < MAXB; b++) begin
        step(); #1;
        if (fifo_wen === 1'b1) nwen++;
        exp_v = {1'b1, 1'b1, 4'b0001 << e, e[1:0]};
        ncmp++;
        if (obs !== exp_v || fifo_din !== dv[e]) begin
          $display("FAIL fair_beat g%0d b%0d: obs=%b din=%h required %b din=%h", g, b, obs, fifo_din, exp_v, dv[e]);
          nerr++;
        end
      end
      step();
    end
    ncmp++;
    if (nwen !== 20) begin
      $display("FAIL fair_util: wen count=%0d required 20", nwen);
      nerr++;
    end
    do_reset();
  endtask

  task automatic test_full_stall;
    int nbeat;
    nbeat = 0;
    req = 4'b0001;
    #1;
    for (int c = 1; c <= 8; c++) begin
      step();
      fifo_full = (c >= 2 && c <= 4);
      #1;
      if (fifo_wen === 1'b1) nbeat++;
      if (c >= 2 && c <= 4)  exp_v = 8'b1000_0000;
      else if (c == 8)       exp_v = 8'b0000_0000;
      else                   exp_v = 8'b1100_0100;
      ncmp++;
      if (obs !== exp_v) begin
        $display("FAIL stall c%0d: obs=%b required %b", c, obs, exp_v);
        nerr++;
      end
    end
    ncmp++;
    if (nbeat !== 4) begin
      $display("FAIL stall_beats: beats=%0d required 4", nbeat);
      nerr++;
    end
    do_reset();
  endtask

  task automatic test_wrap;
    req = 4'b1000;
    #1;
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      ncmp++;
      if (obs !== 8'b1110_0011) begin
        $display("FAIL wrap_beat c%0d: obs=%b required %b", c, obs, 8'b1110_0011);
        nerr++;
      end
    end
    step();
    req = 4'b1001;
    #1;
    ncmp++;
    if (obs !== 8'b0000_0011 || fifo_din !== 8'h44) begin
      $display("FAIL wrap_idle: obs=%b din=%h required %b din=%h", obs, fifo_din, 8'b0000_0011, 8'h44);
      nerr++;
    end
    step(); #1;
    ncmp++;
    if (obs !== 8'b1100_0100 || fifo_din !== 8'h11) begin
      $display("FAIL wrap_grant: obs=%b din=%h required %b din=%h", obs, fifo_din, 8'b1100_0100, 8'h11);
      nerr++;
    end
    req = '0;
    step();
    step();
    do_reset();
  endtask

  task automatic test_reset_mid_burst;
    req = 4'b0100;
    #1;
    for (int c = 1; c <= 3; c++) begin
      step(); #1;
      ncmp++;
      if (obs !== 8'b1101_0010) begin
        $display("FAIL rmid_beat c%0d: obs=%b required %b", c, obs, 8'b1101_0010);
        nerr++;
      end
    end
    rst = 1'b0;
    #1;
    ncmp++;
    if (obs !== 8'b0000_0000) begin
      $display("FAIL rmid_async: obs=%b required %b", obs, 8'b0000_0000);
      nerr++;
    end
    rst = 1'b1;
    #1;
    ncmp++;
    if (obs !== 8'b0000_0000) begin
      $display("FAIL rmid_release: obs=%b required %b", obs, 8'b0000_0000);
      nerr++;
    end
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      ncmp++;
      if (obs !== 8'b1101_0010) begin
        $display("FAIL rmid_fresh c%0d: obs=%b required %b", c, obs, 8'b1101_0010);
        nerr++;
      end
    end
    step(); #1;
    ncmp++;
    if (obs !== 8'b0000_0010) begin
      $display("FAIL rmid_end: obs=%b required %b", obs, 8'b0000_0010);
      nerr++;
    end
    do_reset();
  endtask

  task automatic test_drop_mid_grant;
    req = 4'b0110;
    #1;
    step(); #1;
    ncmp++;
    if (obs !== 8'b1100_1001) begin
      $display("FAIL drop_beat: obs=%b required %b", obs, 8'b1100_1001);
      nerr++;
    end
    step();
    req = 4'b0100;
    #1;
    ncmp++;
    if (obs !== 8'b1000_0001) begin
      $display("FAIL drop_release: obs=%b required %b", obs, 8'b1000_0001);
      nerr++;
    end
    step(); #1;
    ncmp++;
    if (obs !== 8'b0000_0001) begin
      $display("FAIL drop_idle: obs=%b required %b", obs, 8'b0000_0001);
      nerr++;
    end
    step(); #1;
    ncmp++;
    if (obs !== 8'b1101_0010) begin
      $display("FAIL drop_next: obs=%b required %b", obs, 8'b1101_0010);
      nerr++;
    end
    req = '0;
    step();
    step();
  endtask

  initial begin
    dv[0] = 8'h11;
    dv[1] = 8'h22;
    dv[2] = 8'h33;
    dv[3] = 8'h44;
    test_reset();
    test_single();
    test_fairness();
    test_full_stall();
    test_wrap();
    test_reset_mid_burst();
    test_drop_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
